// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter and word-level SPI master (mode 0) for the shared RAM (CS0) and ROM (CS1).
// Each grant runs one 40-bit frame: 8-bit command, 16-bit byte address, then 16 data bits.
module spi_bus_arbiter #(
   parameter logic RR_EN  = 1'b1,
   parameter logic ROM_WP = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_i,
   input  logic        req1_i,
   input  logic        we0_i,
   input  logic        we1_i,
   input  logic [15:0] addr0_i,
   input  logic [15:0] addr1_i,
   input  logic [15:0] wdata0_i,
   input  logic [15:0] wdata1_i,
   output logic        gnt0_o,
   output logic        gnt1_o,
   output logic        done0_o,
   output logic        done1_o,
   output logic [15:0] rdata_o,
   output logic        wp_err_o,
   output logic        spi_cs0_o,
   output logic        spi_cs1_o,
   output logic        spi_clk_o,
   output logic        spi_mosi_o,
   input  logic        spi_miso_i
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_SHIFT = 3'd2,
      S_DONE  = 3'd3,
      S_WPBLK = 3'd4
   } state_e;

   state_e      state_q, state_d;
   logic [6:0]  h_q, h_d;
   logic        last_q, last_d;
   logic        owner_q, owner_d;
   logic        we_q, we_d;
   logic [39:0] frame_q, frame_d;
   logic [15:0] rx_q, rx_d;
   logic [15:0] rdata_q, rdata_d;
   logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic        done0_q, done0_d, done1_q, done1_d;
   logic        wp_err_q, wp_err_d;
   logic        cs0_q, cs0_d, cs1_q, cs1_d;
   logic        sclk_q, sclk_d, mosi_q, mosi_d;

   logic        win_s;
   logic        sel_we_s;
   logic [15:0] sel_addr_s;
   logic [15:0] sel_wdata_s;

   // Next-state and registered-output logic for arbitration and frame shifting.
   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      last_d   = last_q;
      owner_d  = owner_q;
      we_d     = we_q;
      frame_d  = frame_q;
      rx_d     = rx_q;
      rdata_d  = rdata_q;
      gnt0_d   = 1'b0;
      gnt1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      wp_err_d = 1'b0;
      cs0_d    = cs0_q;
      cs1_d    = cs1_q;
      sclk_d   = sclk_q;
      mosi_d   = mosi_q;

      // Round-robin: with both requesting, whoever did not win last time goes next.
      win_s       = RR_EN ? ((req0_i && req1_i) ? ~last_q : req1_i) : ~req0_i;
      sel_we_s    = win_s ? we1_i : we0_i;
      sel_addr_s  = win_s ? addr1_i : addr0_i;
      sel_wdata_s = win_s ? wdata1_i : wdata0_i;

      case (state_q)
         S_IDLE: begin
            if (req0_i || req1_i) begin
               gnt0_d  = ~win_s;
               gnt1_d  = win_s;
               last_d  = win_s;
               owner_d = win_s;
               we_d    = sel_we_s;
               frame_d = {(sel_we_s ? 8'h02 : 8'h03), sel_addr_s[14:0], 1'b0,
                          (sel_we_s ? sel_wdata_s : 16'h0000)};
               if (ROM_WP && sel_we_s && sel_addr_s[15]) begin
                  state_d = S_WPBLK;
               end else begin
                  state_d = S_SETUP;
                  cs0_d   = sel_addr_s[15];
                  cs1_d   = ~sel_addr_s[15];
                  sclk_d  = 1'b0;
                  mosi_d  = frame_d[39];
                  h_d     = 7'd0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            state_d = S_SHIFT;
            h_d     = 7'd0;
            sclk_d  = 1'b0;
         end
         S_SHIFT: begin
            // Read data occupies frame bits 24..39, sampled at the end of each high half.
            if (h_q[0] && (h_q >= 7'd49)) begin
               rx_d = {rx_q[14:0], spi_miso_i};
            end else begin
               rx_d = rx_q;
            end
            if (h_q == 7'd79) begin
               state_d = S_DONE;
               cs0_d   = 1'b1;
               cs1_d   = 1'b1;
               sclk_d  = 1'b0;
               mosi_d  = 1'b0;
            end else begin
               h_d    = h_q + 7'd1;
               sclk_d = ~h_q[0];
               if (h_q[0]) begin
                  frame_d = {frame_q[38:0], 1'b0};
                  mosi_d  = frame_q[38];
               end else begin
                  mosi_d = mosi_q;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done0_d = ~owner_q;
            done1_d = owner_q;
            if (!we_q) begin
               rdata_d = rx_d;
            end else begin
               rdata_d = rdata_q;
            end
         end
         S_WPBLK: begin
            state_d  = S_IDLE;
            done0_d  = ~owner_q;
            done1_d  = owner_q;
            wp_err_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            cs0_d   = 1'b1;
            cs1_d   = 1'b1;
            sclk_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         h_q      <= 7'd0;
         last_q   <= 1'b1;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         frame_q  <= 40'd0;
         rx_q     <= 16'd0;
         rdata_q  <= 16'd0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         wp_err_q <= 1'b0;
         cs0_q    <= 1'b1;
         cs1_q    <= 1'b1;
         sclk_q   <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         frame_q  <= frame_d;
         rx_q     <= rx_d;
         rdata_q  <= rdata_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         wp_err_q <= wp_err_d;
         cs0_q    <= cs0_d;
         cs1_q    <= cs1_d;
         sclk_q   <= sclk_d;
         mosi_q   <= mosi_d;
      end
   end

   assign gnt0_o     = gnt0_q;
   assign gnt1_o     = gnt1_q;
   assign done0_o    = done0_q;
   assign done1_o    = done1_q;
   assign rdata_o    = rdata_q;
   assign wp_err_o   = wp_err_q;
   assign spi_cs0_o  = cs0_q;
   assign spi_cs1_o  = cs1_q;
   assign spi_clk_o  = sclk_q;
   assign spi_mosi_o = mosi_q;

endmodule
